// File: rtl/net_cfg_pkg.sv
// rtl/net_cfg_pkg.sv - shared register map, bit positions and byte-swap helpers
package net_cfg_pkg;

    localparam logic [2:0] REG_IP      = 3'd0;
    localparam logic [2:0] REG_GW      = 3'd1;
    localparam logic [2:0] REG_SUBNET  = 3'd2;
    localparam logic [2:0] REG_MAC_LO  = 3'd3;
    localparam logic [2:0] REG_MAC_HI  = 3'd4;
    localparam logic [2:0] REG_CTRL    = 3'd5;
    localparam logic [2:0] REG_STATUS  = 3'd6;

    localparam int CTRL_COMMIT    = 0;
    localparam int CTRL_REVERT    = 1;
    localparam int STAT_PENDING   = 0;
    localparam int STAT_DIFF      = 1;

    // One interface's identity, stored in host packing ({B3..B0}, {B5..B0})
    typedef struct packed {
        logic [31:0] ip;
        logic [31:0] gw;
        logic [31:0] sn;
        logic [47:0] mac;
    } net_id_t;

    function automatic logic [31:0] swap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [47:0] swap48(input logic [47:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24], x[39:32], x[47:40]};
    endfunction

endpackage

// File: rtl/net_config_if.sv
// rtl/net_config_if.sv - shadow/active/pending state for one network interface
module net_config_if
    import net_cfg_pkg::*;
#(
    parameter logic [31:0] DEF_IP  = '0,
    parameter logic [31:0] DEF_GW  = '0,
    parameter logic [31:0] DEF_SN  = '0,
    parameter logic [47:0] DEF_MAC = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en_i,
    input  logic [2:0]  wr_reg_i,
    input  logic [31:0] wdata_i,
    input  logic        busy_i,
    output net_id_t     shadow_o,
    output net_id_t     active_o,
    output logic        pending_o,
    output logic        update_o
);

    localparam net_id_t DEF = '{ip: DEF_IP, gw: DEF_GW, sn: DEF_SN, mac: DEF_MAC};

    net_id_t shadow_q, shadow_d;
    net_id_t active_q, active_d;
    logic    pending_q, pending_d;
    logic    commit, revert, transfer;

    // Next-state: transfer uses the pre-write shadow; a revert cancels any transfer that cycle
    always_comb begin
        commit    = wr_en_i && (wr_reg_i == REG_CTRL) && wdata_i[CTRL_COMMIT];
        revert    = wr_en_i && (wr_reg_i == REG_CTRL) && wdata_i[CTRL_REVERT];
        transfer  = pending_q && !busy_i && !revert;
        active_d  = transfer ? shadow_q : active_q;
        shadow_d  = shadow_q;
        if (revert) begin
            shadow_d = active_q;
        end else if (wr_en_i) begin
            case (wr_reg_i)
                REG_IP:     shadow_d.ip         = wdata_i;
                REG_GW:     shadow_d.gw         = wdata_i;
                REG_SUBNET: shadow_d.sn         = wdata_i;
                REG_MAC_LO: shadow_d.mac[31:0]  = wdata_i;
                REG_MAC_HI: shadow_d.mac[47:32] = wdata_i[15:0];
                default:    ;
            endcase
        end
        if (revert || transfer) pending_d = 1'b0;
        else if (commit)        pending_d = 1'b1;
        else                    pending_d = pending_q;
    end

    // State registers, defaults restored on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= DEF;
            active_q  <= DEF;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign shadow_o  = shadow_q;
    assign active_o  = active_q;
    assign pending_o = pending_q;
    assign update_o  = transfer;

endmodule

// File: rtl/net_config_block.sv
// rtl/net_config_block.sv - programmable per-interface network identity store
module net_config_block
    import net_cfg_pkg::*;
#(
    parameter int                        C_NUM_IF      = 1,
    parameter logic [32*C_NUM_IF-1:0]    C_DEF_IP      = '0,
    parameter logic [32*C_NUM_IF-1:0]    C_DEF_GATEWAY = '0,
    parameter logic [32*C_NUM_IF-1:0]    C_DEF_SUBNET  = '0,
    parameter logic [48*C_NUM_IF-1:0]    C_DEF_MAC     = '0
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     cfg_wr_en,
    input  logic [5:0]               cfg_addr,
    input  logic [31:0]              cfg_wdata,
    input  logic                     cfg_rd_en,
    output logic [31:0]              cfg_rdata,
    output logic                     cfg_rvalid,
    input  logic [C_NUM_IF-1:0]      net_busy,
    output logic [32*C_NUM_IF-1:0]   ip,
    output logic [32*C_NUM_IF-1:0]   gateway,
    output logic [32*C_NUM_IF-1:0]   subnet,
    output logic [48*C_NUM_IF-1:0]   mac,
    output logic [48*C_NUM_IF-1:0]   mac_big,
    output logic [C_NUM_IF-1:0]      cfg_update
);

    logic [2:0]          if_idx;
    logic [2:0]          reg_idx;
    net_id_t             shadow [C_NUM_IF];
    net_id_t             active [C_NUM_IF];
    logic [C_NUM_IF-1:0] pending;
    logic [31:0]         rd_mux;
    logic [31:0]         cfg_rdata_q;
    logic                cfg_rvalid_q;

    assign if_idx  = cfg_addr[5:3];
    assign reg_idx = cfg_addr[2:0];

    for (genvar g = 0; g < C_NUM_IF; g++) begin : g_if
        net_config_if #(
            .DEF_IP  (C_DEF_IP     [32*g +: 32]),
            .DEF_GW  (C_DEF_GATEWAY[32*g +: 32]),
            .DEF_SN  (C_DEF_SUBNET [32*g +: 32]),
            .DEF_MAC (C_DEF_MAC    [48*g +: 48])
        ) u_if (
            .clk       (aclk),
            .rst_n     (aresetn),
            .wr_en_i   (cfg_wr_en && (if_idx == 3'(g))),
            .wr_reg_i  (reg_idx),
            .wdata_i   (cfg_wdata),
            .busy_i    (net_busy[g]),
            .shadow_o  (shadow[g]),
            .active_o  (active[g]),
            .pending_o (pending[g]),
            .update_o  (cfg_update[g])
        );

        assign ip     [32*g +: 32] = swap32(active[g].ip);
        assign gateway[32*g +: 32] = swap32(active[g].gw);
        assign subnet [32*g +: 32] = swap32(active[g].sn);
        assign mac    [48*g +: 48] = swap48(active[g].mac);
        assign mac_big[48*g +: 48] = active[g].mac;
    end

    // Read mux over shadow state; unmatched interface index falls through to zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < C_NUM_IF; i++) begin
            if (if_idx == 3'(i)) begin
                case (reg_idx)
                    REG_IP:     rd_mux = shadow[i].ip;
                    REG_GW:     rd_mux = shadow[i].gw;
                    REG_SUBNET: rd_mux = shadow[i].sn;
                    REG_MAC_LO: rd_mux = shadow[i].mac[31:0];
                    REG_MAC_HI: rd_mux = {16'h0, shadow[i].mac[47:32]};
                    REG_STATUS: begin
                        rd_mux[STAT_PENDING] = pending[i];
                        rd_mux[STAT_DIFF]    = (shadow[i] != active[i]);
                    end
                    default:    rd_mux = '0;
                endcase
            end
        end
    end

    // Read response register: data captured one cycle after the strobe
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cfg_rdata_q  <= '0;
            cfg_rvalid_q <= 1'b0;
        end else begin
            cfg_rvalid_q <= cfg_rd_en;
            if (cfg_rd_en) cfg_rdata_q <= rd_mux;
        end
    end

    assign cfg_rdata  = cfg_rdata_q;
    assign cfg_rvalid = cfg_rvalid_q;

endmodule
